aes_mix_columns: RTL and testbench

AES MixColumns / InvMixColumns round stage over a 128-bit state. It sits in the AES round datapath after ShiftRows (encrypt) or after AddRoundKey (decrypt). The transform is combinational GF(2^8) matrix arithmetic. The result is captured in an output register with a simple valid qualifier, giving a fixed 1-cycle latency.

---
 rtl/aes_mix_columns.sv | 87 ++++++++
 tb/tb_aes_mix_columns.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_mix_columns.sv
// AES MixColumns / InvMixColumns over a 128-bit FIPS-197 column-major state.
// Pure XOR GF(2^8) logic feeding a single output register; fixed 1-cycle latency.
module aes_mix_columns (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inverse,
  input  logic [127:0] state,
  output logic         out_valid,
  output logic [127:0] mixed_state
);

  localparam int unsigned ByteW   = 8;
  localparam int unsigned RowsW   = 4;
  localparam int unsigned ColW    = ByteW * RowsW;
  localparam int unsigned NumCols = 4;
  localparam int unsigned StateW  = ColW * NumCols;

  logic [StateW-1:0] mixed_state_q, mixed_state_d;
  logic              out_valid_q, out_valid_d;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [ByteW-1:0] xtime(input logic [ByteW-1:0] a);
    return {a[ByteW-2:0], 1'b0} ^ (a[ByteW-1] ? 8'h1b : 8'h00);
  endfunction

  // Transform one column; row 0 sits in the most significant byte.
  function automatic logic [ColW-1:0] mix_col(input logic [ColW-1:0] col,
                                              input logic            inv);
    logic [ByteW-1:0] a  [RowsW];
    logic [ByteW-1:0] x2 [RowsW];
    logic [ByteW-1:0] x4 [RowsW];
    logic [ByteW-1:0] x8 [RowsW];
    logic [ByteW-1:0] m9 [RowsW];
    logic [ByteW-1:0] mb [RowsW];
    logic [ByteW-1:0] md [RowsW];
    logic [ByteW-1:0] me [RowsW];
    logic [ColW-1:0]  res;
    res = '0;
    for (int r = 0; r < int'(RowsW); r++) begin
      a[r]  = col[ColW-1-ByteW*r -: ByteW];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    for (int r = 0; r < int'(RowsW); r++) begin
      if (!inv) begin
        res[ColW-1-ByteW*r -: ByteW] = x2[2'(r)] ^ x2[2'(r+1)] ^ a[2'(r+1)]
                                     ^ a[2'(r+2)] ^ a[2'(r+3)];
      end else begin
        res[ColW-1-ByteW*r -: ByteW] = me[2'(r)] ^ mb[2'(r+1)]
                                     ^ md[2'(r+2)] ^ m9[2'(r+3)];
      end
    end
    return res;
  endfunction

  // Next state: capture a new result when valid, otherwise hold the data.
  always_comb begin
    mixed_state_d = mixed_state_q;
    out_valid_d   = in_valid;
    if (in_valid) begin
      for (int c = 0; c < int'(NumCols); c++) begin
        mixed_state_d[StateW-1-ColW*c -: ColW] =
          mix_col(state[StateW-1-ColW*c -: ColW], inverse);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mixed_state_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      mixed_state_q <= mixed_state_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign mixed_state = mixed_state_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_aes_mix_columns.sv
// Scoreboard bench for aes_mix_columns: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_aes_mix_columns;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inverse;
  logic [127:0] state;
  logic         out_valid;
  logic [127:0] mixed_state;

  logic [127:0] exp_q[$];
  logic [127:0] last_exp;
  int           total;
  int           bad;

  aes_mix_columns dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .inverse     (inverse),
    .state       (state),
    .out_valid   (out_valid),
    .mixed_state (mixed_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) product by shift-and-add, reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      if (aa[7]) aa = (aa << 1) ^ 8'h1b;
      else       aa = aa << 1;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix-vector product applied to each of the four columns.
  function automatic logic [127:0] ref_model(input logic [127:0] st, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   inb  [16];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int k = 0; k < 16; k++) inb[k] = st[127-8*k -: 8];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - r + 4) % 4], inb[4*c + j]);
        res[127-8*(4*c + r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Advance to just after the next rising edge, then present new inputs.
  task automatic step(input logic v, input logic inv, input logic [127:0] st);
    @(posedge clk);
    #1;
    in_valid = v;
    inverse  = inv;
    state    = st;
  endtask

  task automatic issue(input logic inv, input logic [127:0] st, input logic [127:0] exp);
    step(1'b1, inv, st);
    exp_q.push_back(exp);
    last_exp = exp;
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h with no pending expectation", mixed_state);
      end else begin
        check("scoreboard", mixed_state, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  localparam logic [127:0] ColA   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] ColAm  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] ColB   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] ColBm  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] Rnd1   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] Rnd1m  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  initial begin
    logic [127:0] x;
    logic [127:0] y;
    logic         inv;
    total    = 0;
    bad      = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    inverse  = 1'b0;
    state    = rand128();

    // Reset holds outputs clear even with in_valid asserted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_valid", 128'(out_valid), 128'(1'b0));
      check("reset_data", mixed_state, 128'h0);
      state = rand128();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Known-answer vectors, one per cycle with gaps.
    issue(1'b0, ColA, ColAm);
    step(1'b0, 1'b1, rand128());
    issue(1'b0, ColB, ColBm);
    issue(1'b0, Rnd1, Rnd1m);
    issue(1'b1, Rnd1m, Rnd1);
    step(1'b0, 1'b0, rand128());

    // Streaming: alternating direction, no bubbles.
    issue(1'b0, ColA,  ColAm);
    issue(1'b1, ColAm, ColA);
    issue(1'b0, ColB,  ColBm);
    issue(1'b1, ColBm, ColB);
    issue(1'b0, Rnd1,  Rnd1m);
    issue(1'b1, Rnd1m, Rnd1);
    issue(1'b0, ColA,  ColAm);
    issue(1'b1, ColBm, ColB);
    step(1'b0, 1'b0, rand128());
    @(posedge clk);
    #1;
    check("drop_valid", 128'(out_valid), 128'(1'b0));
    check("hold_data", mixed_state, last_exp);
    state   = rand128();
    inverse = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ignores_inputs", mixed_state, last_exp);

    // Random states, random direction, occasional idle cycles, one reset pulse.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        step(1'b1, 1'b0, rand128());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midstream_reset_valid", 128'(out_valid), 128'(1'b0));
        check("midstream_reset_data", mixed_state, 128'h0);
        rst_n = 1'b1;
        in_valid = 1'b0;
      end
      x   = rand128();
      inv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) step(1'b0, inv, x);
      else                           issue(inv, x, ref_model(x, inv));
    end

    // Round trip: forward result fed back through inverse must return x.
    for (int i = 0; i < 20; i++) begin
      x = rand128();
      y = ref_model(x, 1'b0);
      issue(1'b0, x, y);
      issue(1'b1, y, x);
    end

    step(1'b0, 1'b0, rand128());
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
